// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed byte stream, packs little-endian 32-bit words,
// writes them to instruction memory and keeps the core in reset until the load completes.
module imem_boot_loader #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH_WORDS = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  load_req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    logic [2:0]            state_reg;
    logic [1:0]            byte_cnt_reg;
    logic [31:0]           len_reg;
    logic [31:0]           idx_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [23:0]           word_reg;

    logic                  accept;
    logic                  last_byte;
    logic [31:0]           assembled;
    logic [31:0]           idx_inc;

    assign accept    = byte_valid & byte_ready;
    assign last_byte = accept && (byte_cnt_reg == 2'd3);
    // The 4th byte is taken straight from the input, so only lanes 0..2 are stored.
    assign assembled = {byte_data, word_reg};
    assign idx_inc   = idx_reg + 32'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_reg <= '0;
                end else if (accept && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg <= byte_data;
                end
            end
            assign word_reg[8*gi +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_INIT;
            byte_cnt_reg <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            addr_reg     <= BASE_ADDR;
            wdata_reg    <= '0;
        end else begin
            // Counter wraps to 0 after the 4th byte of each group.
            if (accept) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            case (state_reg)
                ST_INIT: state_reg <= ST_LEN;
                ST_LEN: begin
                    if (last_byte) begin
                        len_reg <= assembled;
                        idx_reg <= '0;
                        if (assembled == 32'd0) begin
                            state_reg <= ST_DONE;
                        end else if (assembled > 32'(DEPTH_WORDS)) begin
                            state_reg <= ST_ERROR;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (last_byte) begin
                        wdata_reg <= assembled;
                        addr_reg  <= BASE_ADDR + (ADDR_WIDTH'(idx_reg) << 2);
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    idx_reg   <= idx_inc;
                    state_reg <= (idx_inc == len_reg) ? ST_DONE : ST_DATA;
                end
                ST_DONE, ST_ERROR: begin
                    if (load_req) begin
                        state_reg    <= ST_LEN;
                        byte_cnt_reg <= '0;
                        len_reg      <= '0;
                        idx_reg      <= '0;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign byte_ready = (state_reg == ST_LEN) || (state_reg == ST_DATA);
    assign imem_we    = (state_reg == ST_WRITE);
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign core_hold  = (state_reg != ST_DONE);
    assign load_done  = (state_reg == ST_DONE);
    assign load_err   = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random programs and byte gaps,
// expected writes derived from the stream contents.
module tb_imem_boot_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic        load_req   = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;
    bit gaps     = 1'b0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] prog[$];

    imem_boot_loader #(
        .ADDR_WIDTH (32),
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .load_req  (load_req),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
            $display("write addr=%08h data=%08h", imem_addr, imem_wdata);
            check("ready_in_write", byte_ready, 1'b0);
            check("hold_in_write", core_hold, 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            @(negedge clk);
            acc = byte_ready;
            tick();
            n++;
        end while (!acc && n < 40);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        check("byte_accept", acc, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Reference: word i of the program lands at BASE + 4*i.
    task automatic expect_prog();
        for (int i = 0; i < prog.size(); i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(prog[i]);
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_count"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            check({tag, "_data"}, obs_data[i], exp_data[i]);
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic run_program(input string tag, input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
        send_word(32'(n));
        for (int i = 0; i < n; i++) begin
            send_word(prog[i]);
            check({tag, "_we_latency"}, imem_we, 1'b1);
        end
        tick();
        check({tag, "_done"}, load_done, 1'b1);
        check({tag, "_hold"}, core_hold, 1'b0);
        check({tag, "_we_off"}, imem_we, 1'b0);
        expect_prog();
        compare_writes(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] w0;
        // Reset values.
        repeat (2) tick();
        check("rst_ready", byte_ready, 1'b0);
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_hold", core_hold, 1'b1);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_err, 1'b0);
        reset = 1'b1;
        tick();
        check("len_ready", byte_ready, 1'b1);

        // Single-word directed program.
        send_word(32'd1);
        send_word(32'h00A00513);
        check("t1_we", imem_we, 1'b1);
        check("t1_addr", imem_addr, BASE);
        check("t1_wdata", imem_wdata, 32'h00A00513);
        tick();
        check("t1_we_off", imem_we, 1'b0);
        check("t1_hold", core_hold, 1'b0);
        check("t1_done", load_done, 1'b1);
        prog.delete(); prog.push_back(32'h00A00513);
        expect_prog();
        compare_writes("t1");

        // Three words with random byte_valid gaps.
        pulse_load_req();
        check("t2_hold", core_hold, 1'b1);
        check("t2_done_clr", load_done, 1'b0);
        check("t2_ready", byte_ready, 1'b1);
        gaps = 1'b1;
        run_program("t2", 3);

        // Full-capacity program.
        pulse_load_req();
        gaps = 1'b0;
        run_program("full", DEPTH);

        // Zero-length program.
        pulse_load_req();
        gaps = 1'b1;
        send_word(32'd0);
        check("t3_done", load_done, 1'b1);
        check("t3_hold", core_hold, 1'b0);
        check("t3_ready", byte_ready, 1'b0);
        repeat (3) tick();
        compare_writes("t3");

        // Oversized length header.
        pulse_load_req();
        send_word(32'(DEPTH + 1));
        check("t4_err", load_err, 1'b1);
        check("t4_hold", core_hold, 1'b1);
        check("t4_ready", byte_ready, 1'b0);
        check("t4_done", load_done, 1'b0);
        pulse_load_req();
        check("t4_err_clr", load_err, 1'b0);
        check("t4_ready_len", byte_ready, 1'b1);

        // Asynchronous reset in the middle of word 1.
        w0 = $urandom;
        send_word(32'd2);
        send_word(w0);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        #2;
        reset = 1'b0;
        #1;
        check("t5_ready", byte_ready, 1'b0);
        check("t5_we", imem_we, 1'b0);
        check("t5_addr", imem_addr, BASE);
        check("t5_wdata", imem_wdata, 32'h0);
        check("t5_hold", core_hold, 1'b1);
        check("t5_done", load_done, 1'b0);
        check("t5_err", load_err, 1'b0);
        prog.delete(); prog.push_back(w0);
        expect_prog();
        compare_writes("t5_pre");
        tick();
        reset = 1'b1;
        tick();

        // Fresh load after reset; load_req in DATA is ignored.
        prog.delete();
        prog.push_back($urandom);
        prog.push_back($urandom);
        send_word(32'd2);
        send_word(prog[0]);
        send_byte(prog[1][7:0]);
        pulse_load_req();
        check("t6_ignored_ready", byte_ready, 1'b1);
        check("t6_ignored_done", load_done, 1'b0);
        send_byte(prog[1][15:8]);
        send_byte(prog[1][23:16]);
        send_byte(prog[1][31:24]);
        check("t6_we", imem_we, 1'b1);
        tick();
        check("t6_done", load_done, 1'b1);
        expect_prog();
        compare_writes("t6");

        // Reload from DONE.
        pulse_load_req();
        check("t6b_hold", core_hold, 1'b1);
        check("t6b_done_clr", load_done, 1'b0);
        run_program("t6b", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
